// File: rtl/blt_update_ctrl.sv
// Write-side controller for the branch lookup table: two-requester round-robin
// intake, in-order update FIFO, one BLT write per cycle, and a drain/clear/ack flush.
module blt_update_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_key,
    input  logic [ADDR_WIDTH-1:0] a_val,
    input  logic                  a_hit,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_key,
    input  logic [ADDR_WIDTH-1:0] b_val,
    input  logic                  b_hit,
    output logic                  b_ready,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  blt_write,
    output logic [ADDR_WIDTH-1:0] blt_key,
    output logic [ADDR_WIDTH-1:0] blt_val,
    output logic                  blt_hit,
    output logic                  blt_clear,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  busy
);

    localparam int PTR_W = CNT_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic                   prio_q, prio_d;
    logic                   write_q, write_d;
    logic [ADDR_WIDTH-1:0]  key_q, key_d;
    logic [ADDR_WIDTH-1:0]  val_q, val_d;
    logic                   hit_q, hit_d;
    logic                   clear_q, clear_d;
    logic                   done_q, done_d;

    logic [ADDR_WIDTH-1:0]  key_mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  val_mem_q [FIFO_DEPTH];
    logic                   hit_mem_q [FIFO_DEPTH];

    logic                   accept_ok_s;
    logic                   push_s;
    logic                   pop_s;
    logic [ADDR_WIDTH-1:0]  push_key_s;
    logic [ADDR_WIDTH-1:0]  push_val_s;
    logic                   push_hit_s;

    // Full is judged on current occupancy only; a same-cycle pop does not open a slot.
    assign accept_ok_s = (state_q == ST_IDLE) && !flush_req && (cnt_q != FULL_CNT);
    assign a_ready     = accept_ok_s && a_valid && (!b_valid || !prio_q);
    assign b_ready     = accept_ok_s && b_valid && (!a_valid || prio_q);
    assign push_s      = (a_valid && a_ready) || (b_valid && b_ready);
    assign pop_s       = (cnt_q != {CNT_WIDTH{1'b0}});
    assign push_key_s  = a_ready ? a_key : b_key;
    assign push_val_s  = a_ready ? a_val : b_val;
    assign push_hit_s  = a_ready ? a_hit : b_hit;

    // FIFO bookkeeping, arbitration priority and issue-register next state
    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        prio_d   = prio_q;
        write_d  = 1'b0;
        key_d    = key_q;
        val_d    = val_q;
        hit_d    = hit_q;
        if (push_s && !pop_s) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (!push_s && pop_s) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            write_d  = 1'b1;
            key_d    = key_mem_q[rd_ptr_q];
            val_d    = val_mem_q[rd_ptr_q];
            hit_d    = hit_mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Priority passes to whichever requester was not just served.
        if (a_valid && a_ready) begin
            prio_d = 1'b1;
        end else if (b_valid && b_ready) begin
            prio_d = 1'b0;
        end else begin
            prio_d = prio_q;
        end
    end

    // Flush sequencer next state; clear/done pulses trail their state by one cycle
    always_comb begin
        state_d = state_q;
        clear_d = (state_q == ST_CLEAR);
        done_d  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Wait until the last write has actually been presented to the BLT.
                if ((cnt_q == {CNT_WIDTH{1'b0}}) && !write_q) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_WIDTH{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            prio_q   <= 1'b0;
            write_q  <= 1'b0;
            key_q    <= {ADDR_WIDTH{1'b0}};
            val_q    <= {ADDR_WIDTH{1'b0}};
            hit_q    <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            prio_q   <= prio_d;
            write_q  <= write_d;
            key_q    <= key_d;
            val_q    <= val_d;
            hit_q    <= hit_d;
            clear_q  <= clear_d;
            done_q   <= done_d;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count says empty
    always_ff @(posedge clk) begin
        if (push_s && reset) begin
            key_mem_q[wr_ptr_q] <= push_key_s;
            val_mem_q[wr_ptr_q] <= push_val_s;
            hit_mem_q[wr_ptr_q] <= push_hit_s;
        end
    end

    assign blt_write  = write_q;
    assign blt_key    = key_q;
    assign blt_val    = val_q;
    assign blt_hit    = hit_q;
    assign blt_clear  = clear_q;
    assign flush_done = done_q;
    assign occupancy  = cnt_q;
    assign busy       = (state_q != ST_IDLE) || (cnt_q != {CNT_WIDTH{1'b0}}) || write_q;

endmodule
